// File: rtl/ro_meter_pkg.sv
// Shared types and constants for the multi-channel ring-oscillator frequency meter.
package ro_meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GATE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int DEF_NUM_RO    = 4;
    localparam int DEF_RO_STAGES = 5;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_GATE_W    = 10;
    localparam int DEF_PRE_W     = 2;

    // Cycles spent after the gate so edges already inside the synchroniser still land.
    localparam int DRAIN_LEN = 3;

    localparam int UIO_BUSY = 7;
    localparam int UIO_DONE = 6;
    localparam int UIO_OVF  = 5;

    localparam logic [7:0] UIO_OE_VAL = 8'b1110_0000;

endpackage

// File: rtl/ro_channel.sv
// One enable-gated ring oscillator followed by a ripple prescaler clocked by the ring itself.
module ro_channel #(
    parameter int RO_STAGES = 5,
    parameter int PRE_W     = 2
) (
    input  logic rst_n,
    input  logic en,
    output logic div_out
);

    (* keep = "true", dont_touch = "true" *) logic [RO_STAGES-1:0] stage;
    logic [PRE_W-1:0] pre_cnt;

    // The NAND is the first stage; with en low the ring settles to a static state.
    assign stage[0] = ~(en & stage[RO_STAGES-1]);

    for (genvar i = 1; i < RO_STAGES; i++) begin : g_inv
        assign stage[i] = ~stage[i-1];
    end

    always_ff @(posedge stage[RO_STAGES-1] or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign div_out = pre_cnt[PRE_W-1];

endmodule

// File: rtl/tt_um_ro_multi_meter.sv
// Gated edge counter measuring one of several ring oscillators (or an external
// test source) over a 2^GATE_W clock window, with a byte-wide result readout.
module tt_um_ro_multi_meter
    import ro_meter_pkg::*;
#(
    parameter int NUM_RO    = DEF_NUM_RO,
    parameter int RO_STAGES = DEF_RO_STAGES,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int GATE_W    = DEF_GATE_W,
    parameter int PRE_W     = DEF_PRE_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int NBYTES = CNT_W / 8;

    state_t state, state_next;

    logic              start_prev;
    logic              start_ev;
    logic [2:0]        ch_q;
    logic              byp_q;
    logic [2:0]        ch_active;
    logic              byp_active;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  edge_next;
    logic [CNT_W-1:0]  result;
    logic              ovf;
    logic [GATE_W-1:0] win;
    logic [1:0]        drain_cnt;
    logic              gate_end;
    logic              drain_end;
    logic              sync1, sync2, sync3;
    logic              src;
    logic              rise;
    logic              busy, done, counting;
    logic [NUM_RO-1:0] ring_en;
    logic [NUM_RO-1:0] pre_out;
    logic              unused;

    assign unused    = &{1'b0, uio_in[7:1]};
    assign start_ev  = ui_in[0] & ~start_prev;
    assign gate_end  = (win == '1);
    assign drain_end = (state == ST_DRAIN) && (drain_cnt == 2'(DRAIN_LEN - 1));
    assign rise      = sync2 & ~sync3;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (start_ev) state_next = ST_CLEAR;
            ST_CLEAR:         state_next = ST_GATE;
            ST_GATE:          if (gate_end) state_next = ST_DRAIN;
            ST_DRAIN:         if (drain_end) state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
        if (!ena) state_next = ST_IDLE;
    end

    // FSM: outputs
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        counting = 1'b0;
        case (state)
            ST_CLEAR: busy = ena;
            ST_GATE:  begin busy = ena; counting = 1'b1; end
            ST_DRAIN: begin busy = ena; counting = 1'b1; end
            ST_DONE:  done = ena;
            default:  ;
        endcase
    end

    // The ring comes up during CLEAR, before the latch has taken the new select.
    always_comb begin
        ch_active  = (state == ST_CLEAR) ? ui_in[4:2] : ch_q;
        byp_active = (state == ST_CLEAR) ? ui_in[1]   : byp_q;
        ring_en    = '0;
        for (int i = 0; i < NUM_RO; i++) begin
            if (busy && !byp_active && ch_active == 3'(i)) ring_en[i] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_RO; i++) begin : g_ch
        ro_channel #(
            .RO_STAGES(RO_STAGES),
            .PRE_W    (PRE_W)
        ) u_ch (
            .rst_n  (rst_n),
            .en     (ring_en[i]),
            .div_out(pre_out[i])
        );
    end

    // Out-of-range channels match no loop index and leave the source at 0.
    always_comb begin
        src = 1'b0;
        for (int i = 0; i < NUM_RO; i++) begin
            if (ch_q == 3'(i)) src = byp_q ? uio_in[0] : pre_out[i];
        end
    end

    always_comb begin
        edge_next = edge_cnt;
        if (counting && rise && edge_cnt != '1) edge_next = edge_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev <= 1'b0;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            ch_q       <= '0;
            byp_q      <= 1'b0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
            win        <= '0;
            drain_cnt  <= '0;
            result     <= '0;
        end else begin
            start_prev <= ui_in[0];
            // Each window starts from a known-low synchroniser so stale samples from
            // the previous source cannot be counted.
            if (state == ST_CLEAR) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                sync3 <= 1'b0;
            end else begin
                sync1 <= src;
                sync2 <= sync1;
                sync3 <= sync2;
            end
            if (state == ST_CLEAR) begin
                ch_q      <= ui_in[4:2];
                byp_q     <= ui_in[1];
                edge_cnt  <= '0;
                ovf       <= 1'b0;
                win       <= '0;
                drain_cnt <= '0;
                result    <= '0;
            end else begin
                edge_cnt <= edge_next;
                if (counting && rise && edge_cnt == '1) ovf <= 1'b1;
                if (state == ST_GATE) win <= win + GATE_W'(1);
                if (state == ST_DRAIN) drain_cnt <= drain_cnt + 2'(1);
                if (drain_end && ena) result <= edge_next;
            end
        end
    end

    always_comb begin
        uo_out = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if (ui_in[7:5] == 3'(b)) uo_out = result[8*b +: 8];
        end
    end

    always_comb begin
        uio_out           = '0;
        uio_out[UIO_BUSY] = busy;
        uio_out[UIO_DONE] = done;
        uio_out[UIO_OVF]  = ovf;
    end

    assign uio_oe = UIO_OE_VAL;

endmodule
